freepdk45_sram_1w1r_param: RTL and testbench

//  Parametrised single-clock 1W1R SRAM behavioural model for the FreePDK45 macro set.

---
 rtl/freepdk45_sram_1w1r_param.sv | 162 ++++++++++++++++
 tb/tb_freepdk45_sram_1w1r_param.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freepdk45_sram_1w1r_param.sv
// Parametrised single-clock 1W1R SRAM behavioural model (FreePDK45 macro family).
// Port 0 writes with per-lane masking, port 1 reads with a 1..4 cycle pipeline.
// Optional read-during-write bypass, collision flagging and post-reset zero fill.
module freepdk45_sram_1w1r_param #(
   parameter int DATA_WIDTH   = 44,
   parameter int WRITE_SIZE   = 11,
   parameter int ADDR_WIDTH   = 7,
   parameter int READ_LATENCY = 1,
   parameter int BYPASS       = 1,
   parameter int ZERO_INIT    = 1,
   parameter int VERBOSE      = 0
) (
   input  logic                             clk0,
   input  logic                             rst0,
   input  logic                             csb0,
   input  logic [DATA_WIDTH/WRITE_SIZE-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0]            addr0,
   input  logic [DATA_WIDTH-1:0]            din0,
   input  logic                             csb1,
   input  logic [ADDR_WIDTH-1:0]            addr1,
   output logic [DATA_WIDTH-1:0]            dout1,
   output logic                             dout1_valid,
   output logic                             collision,
   output logic                             init_busy
);

   localparam int NUM_WMASKS = DATA_WIDTH / WRITE_SIZE;
   localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

   // Reject configurations the model cannot represent faithfully.
   if ((DATA_WIDTH % WRITE_SIZE) != 0) begin : g_bad_write_size
      $error("DATA_WIDTH must be a multiple of WRITE_SIZE");
   end
   if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
      $error("READ_LATENCY must be in 1..4");
   end
   if ((VERBOSE != 0) && (VERBOSE != 1)) begin : g_bad_verbose
      $error("VERBOSE must be 0 or 1");
   end

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_cnt;
   logic [ADDR_WIDTH-1:0]   w_cnt_nxt;
   logic                    r_init_busy;
   logic                    w_init_we;
   logic                    w_wr_en;
   logic                    w_rd_en;
   logic [DATA_WIDTH-1:0]   r_mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0]   w_rd_data;
   logic                    w_rd_col;
   logic [READ_LATENCY-1:0] r_vld;
   logic [READ_LATENCY-1:0] r_col;
   logic [DATA_WIDTH-1:0]   r_dat [READ_LATENCY];

   // State register: reset lands in INIT (zero fill) or straight in READY.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         r_state     <= (ZERO_INIT != 0) ? ST_INIT : ST_READY;
         r_cnt       <= '0;
         r_init_busy <= (ZERO_INIT != 0);
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_init_busy <= (w_state_nxt == ST_INIT);
      end
   end

   // Next state and port enables; both ports are ignored while clearing.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_init_we   = 1'b0;
      w_wr_en     = 1'b0;
      w_rd_en     = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_init_we = 1'b1;
            w_cnt_nxt = r_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
               w_state_nxt = ST_READY;
            end else begin
               w_state_nxt = ST_INIT;
            end
         end
         ST_READY: begin
            w_wr_en = ~csb0;
            w_rd_en = ~csb1;
         end
         default: begin
            w_state_nxt = ST_READY;
         end
      endcase
   end

   // Storage: zero fill during INIT, masked lane writes in READY; the reset edge writes nothing.
   always_ff @(posedge clk0) begin
      if (!rst0) begin
         if (w_init_we) begin
            r_mem[r_cnt] <= '0;
         end else if (w_wr_en) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
               if (wmask0[i]) begin
                  r_mem[addr0][i*WRITE_SIZE +: WRITE_SIZE] <= din0[i*WRITE_SIZE +: WRITE_SIZE];
               end
            end
         end
      end
   end

   // Read word as of this edge; on a same-address write, bypass merges the masked new lanes.
   always_comb begin
      w_rd_data = r_mem[addr1];
      w_rd_col  = w_rd_en && w_wr_en && (addr0 == addr1);
      if (w_rd_col && (BYPASS != 0)) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
               w_rd_data[i*WRITE_SIZE +: WRITE_SIZE] = din0[i*WRITE_SIZE +: WRITE_SIZE];
            end else begin
               w_rd_data[i*WRITE_SIZE +: WRITE_SIZE] = r_mem[addr1][i*WRITE_SIZE +: WRITE_SIZE];
            end
         end
      end else begin
         w_rd_data = r_mem[addr1];
      end
   end

   // Read pipeline: each stage holds its last valid word, so the final stage doubles as the held dout1.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         r_vld <= '0;
         r_col <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_dat[i] <= '0;
         end
      end else begin
         r_vld[0] <= w_rd_en;
         r_col[0] <= w_rd_col;
         if (w_rd_en) begin
            r_dat[0] <= w_rd_data;
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_col[i] <= r_col[i-1];
            if (r_vld[i-1]) begin
               r_dat[i] <= r_dat[i-1];
            end
         end
      end
   end

   assign dout1       = r_dat[READ_LATENCY-1];
   assign dout1_valid = r_vld[READ_LATENCY-1];
   assign collision   = r_col[READ_LATENCY-1];
   assign init_busy   = r_init_busy;

endmodule

// File: tb/tb_freepdk45_sram_1w1r_param.sv
// Bench for freepdk45_sram_1w1r_param: two instances share stimulus.
//  dut_a: READ_LATENCY=1, BYPASS=1, ZERO_INIT=1
//  dut_b: READ_LATENCY=3, BYPASS=0, ZERO_INIT=0
// Expected read results are queued when a read is issued and popped on dout1_valid.
module tb_freepdk45_sram_1w1r_param;

   localparam logic [43:0] ONES = {44{1'b1}};
   localparam logic [43:0] L02  = {11'h000, 11'h7FF, 11'h000, 11'h7FF};
   localparam logic [43:0] W5   = 44'hABC_DEF0_1234;
   localparam logic [43:0] W7   = 44'h123_4567_89A;
   localparam logic [43:0] W10  = 44'h000_0000_0123;
   localparam logic [43:0] W10M = {11'h7FF, 33'h0_0000_0123};
   localparam logic [43:0] W127 = 44'hFED_CBA9_8765;
   localparam logic [43:0] W2   = 44'h000_0000_0555;

   logic        clk0 = 1'b0;
   logic        rst0;
   logic        csb0;
   logic [3:0]  wmask0;
   logic [6:0]  addr0;
   logic [43:0] din0;
   logic        csb1;
   logic [6:0]  addr1;
   logic [43:0] dout1_a, dout1_b;
   logic        dout1_valid_a, dout1_valid_b;
   logic        collision_a, collision_b;
   logic        init_busy_a, init_busy_b;

   typedef struct packed {
      logic [43:0] d;
      logic        c;
   } exp_t;

   typedef struct {
      logic        cs0;
      logic [3:0]  wm;
      logic [6:0]  a0;
      logic [43:0] d0;
      logic        cs1;
      logic [6:0]  a1;
      logic [43:0] ea;
      logic [43:0] eb;
      logic        ec;
   } vec_t;

   exp_t qa[$];
   exp_t qb[$];
   vec_t tbl[16];
   int   n_cmp = 0;
   int   n_err = 0;
   int   va_seen = 0;
   int   vb_seen = 0;

   freepdk45_sram_1w1r_param #(
      .DATA_WIDTH(44), .WRITE_SIZE(11), .ADDR_WIDTH(7),
      .READ_LATENCY(1), .BYPASS(1), .ZERO_INIT(1), .VERBOSE(0)
   ) dut_a (
      .clk0(clk0), .rst0(rst0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0),
      .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(dout1_a),
      .dout1_valid(dout1_valid_a), .collision(collision_a), .init_busy(init_busy_a)
   );

   freepdk45_sram_1w1r_param #(
      .DATA_WIDTH(44), .WRITE_SIZE(11), .ADDR_WIDTH(7),
      .READ_LATENCY(3), .BYPASS(0), .ZERO_INIT(0), .VERBOSE(0)
   ) dut_b (
      .clk0(clk0), .rst0(rst0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0),
      .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(dout1_b),
      .dout1_valid(dout1_valid_b), .collision(collision_b), .init_busy(init_busy_b)
   );

   always #5 clk0 = ~clk0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk0);
      #1;
   endtask

   task automatic idle();
      csb0   = 1'b1;
      csb1   = 1'b1;
      wmask0 = 4'h0;
      addr0  = 7'd0;
      din0   = 44'h0;
      addr1  = 7'd0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (((qa.size() != 0) || (qb.size() != 0)) && (k < 20)) begin
         tick();
         k++;
      end
      check("queues_drained", 64'(qa.size() + qb.size()), 64'd0);
   endtask

   // Scoreboard for dut_a: every valid pulse must match the oldest queued expectation.
   always @(negedge clk0) begin : mon_a
      exp_t e;
      if (!rst0 && dout1_valid_a) begin
         va_seen++;
         if (qa.size() == 0) begin
            check("unexpected_valid_a", 64'd1, 64'd0);
         end else begin
            e = qa.pop_front();
            check("dout1_a", 64'(dout1_a), 64'(e.d));
            check("collision_a", 64'(collision_a), 64'(e.c));
         end
      end else if (!rst0 && collision_a) begin
         check("stray_collision_a", 64'd1, 64'd0);
      end
   end

   // Scoreboard for dut_b.
   always @(negedge clk0) begin : mon_b
      exp_t e;
      if (!rst0 && dout1_valid_b) begin
         vb_seen++;
         if (qb.size() == 0) begin
            check("unexpected_valid_b", 64'd1, 64'd0);
         end else begin
            e = qb.pop_front();
            check("dout1_b", 64'(dout1_b), 64'(e.d));
            check("collision_b", 64'(collision_b), 64'(e.c));
         end
      end else if (!rst0 && collision_b) begin
         check("stray_collision_b", 64'd1, 64'd0);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      int n;
      int va0;
      int vb0;
      logic bflag;

      //          cs0   wm     a0      d0    cs1   a1      ea     eb    ec
      tbl[0]  = '{1'b0, 4'hF, 7'd5,   W5,   1'b1, 7'd0,   44'h0, 44'h0, 1'b0};
      tbl[1]  = '{1'b1, 4'h0, 7'd0,   44'h0, 1'b0, 7'd5,  W5,    W5,    1'b0};
      tbl[2]  = '{1'b0, 4'h5, 7'd9,   ONES, 1'b1, 7'd0,   44'h0, 44'h0, 1'b0};
      tbl[3]  = '{1'b1, 4'h0, 7'd0,   44'h0, 1'b0, 7'd9,  L02,   L02,   1'b0};
      tbl[4]  = '{1'b0, 4'h1, 7'd3,   ONES, 1'b0, 7'd3,   44'h7FF, 44'h0, 1'b1};
      tbl[5]  = '{1'b1, 4'h0, 7'd0,   44'h0, 1'b0, 7'd3,  44'h7FF, 44'h7FF, 1'b0};
      tbl[6]  = '{1'b0, 4'h0, 7'd9,   44'h0, 1'b0, 7'd9,  L02,   L02,   1'b1};
      tbl[7]  = '{1'b0, 4'hF, 7'd10,  W10,  1'b0, 7'd5,   W5,    W5,    1'b0};
      tbl[8]  = '{1'b1, 4'hF, 7'd5,   44'h0, 1'b0, 7'd10, W10,   W10,   1'b0};
      tbl[9]  = '{1'b0, 4'h8, 7'd10,  ONES, 1'b0, 7'd10,  W10M,  W10,   1'b1};
      tbl[10] = '{1'b1, 4'h0, 7'd0,   44'h0, 1'b0, 7'd5,  W5,    W5,    1'b0};
      tbl[11] = '{1'b0, 4'hF, 7'd127, W127, 1'b0, 7'd0,   44'h0, 44'h0, 1'b0};
      tbl[12] = '{1'b0, 4'hF, 7'd7,   W7,   1'b0, 7'd127, W127,  W127,  1'b0};
      tbl[13] = '{1'b0, 4'h2, 7'd0,   ONES, 1'b0, 7'd10,  W10M,  W10M,  1'b0};
      tbl[14] = '{1'b1, 4'h0, 7'd0,   44'h0, 1'b0, 7'd0,  {22'h0, 11'h7FF, 11'h0}, {22'h0, 11'h7FF, 11'h0}, 1'b0};
      tbl[15] = '{1'b1, 4'h0, 7'd0,   44'h0, 1'b0, 7'd7,  W7,    W7,    1'b0};

      // Reset and reset-state outputs.
      rst0 = 1'b1;
      idle();
      repeat (3) @(posedge clk0);
      #1;
      check("reset_dout1_a", 64'(dout1_a), 64'd0);
      check("reset_valid_a", 64'(dout1_valid_a), 64'd0);
      check("reset_init_busy_a", 64'(init_busy_a), 64'd1);
      check("reset_init_busy_b", 64'(init_busy_b), 64'd0);
      rst0 = 1'b0;

      // Zero fill on dut_a; meanwhile zero every word of dut_b through port 0.
      n = 0;
      bflag = 1'b0;
      while (init_busy_a && (n < 200)) begin
         if (init_busy_b) bflag = 1'b1;
         csb0   = 1'b0;
         wmask0 = 4'hF;
         addr0  = n[6:0];
         din0   = 44'h0;
         n++;
         tick();
      end
      idle();
      check("init_busy_cycles_a", 64'(n), 64'd128);
      check("init_busy_b_low", 64'(bflag), 64'd0);

      // Every address reads back zero.
      for (int a = 0; a < 128; a++) begin
         csb1  = 1'b0;
         addr1 = 7'(a);
         qa.push_back(exp_t'{44'h0, 1'b0});
         qb.push_back(exp_t'{44'h0, 1'b0});
         tick();
      end
      idle();
      drain();

      // Table of writes, reads, masks and collisions.
      for (int i = 0; i < 16; i++) begin
         csb0   = tbl[i].cs0;
         wmask0 = tbl[i].wm;
         addr0  = tbl[i].a0;
         din0   = tbl[i].d0;
         csb1   = tbl[i].cs1;
         addr1  = tbl[i].a1;
         if (!tbl[i].cs1) begin
            qa.push_back(exp_t'{tbl[i].ea, tbl[i].ec});
            qb.push_back(exp_t'{tbl[i].eb, tbl[i].ec});
         end
         tick();
      end
      idle();
      drain();

      // Three back-to-back reads, reset right after dut_b's first valid pulse.
      va0 = va_seen;
      vb0 = vb_seen;
      for (int k = 0; k < 3; k++) begin
         csb1  = 1'b0;
         addr1 = 7'd5;
         qa.push_back(exp_t'{W5, 1'b0});
         qb.push_back(exp_t'{W5, 1'b0});
         tick();
      end
      idle();
      @(negedge clk0);
      #1;
      rst0 = 1'b1;
      qb.delete();
      #1;
      check("flush_valids_a", 64'(va_seen - va0), 64'd3);
      check("flush_first_valid_b", 64'(vb_seen - vb0), 64'd1);
      check("flush_dout1_b", 64'(dout1_b), 64'd0);
      check("flush_valid_b", 64'(dout1_valid_b), 64'd0);
      check("flush_dout1_a", 64'(dout1_a), 64'd0);
      repeat (2) @(posedge clk0);
      #1;
      rst0 = 1'b0;

      // dut_a re-clears and ignores both ports; dut_b keeps contents and serves reads.
      va0 = va_seen;
      n = 0;
      bflag = 1'b0;
      while (init_busy_a && (n < 200)) begin
         idle();
         if (init_busy_b) bflag = 1'b1;
         if (n == 2) begin
            csb1  = 1'b0;
            addr1 = 7'd7;
            qb.push_back(exp_t'{W7, 1'b0});
         end
         if (n == 115) begin
            csb0   = 1'b0;
            wmask0 = 4'hF;
            addr0  = 7'd2;
            din0   = W2;
         end
         n++;
         tick();
      end
      idle();
      check("reinit_cycles_a", 64'(n), 64'd128);
      check("reinit_init_busy_b_low", 64'(bflag), 64'd0);
      check("no_valid_during_init_a", 64'(va_seen - va0), 64'd0);
      check("flush_total_valids_b", 64'(vb_seen - vb0), 64'd2);

      // Cleared vs retained contents.
      csb1  = 1'b0;
      addr1 = 7'd2;
      qa.push_back(exp_t'{44'h0, 1'b0});
      qb.push_back(exp_t'{W2, 1'b0});
      tick();
      addr1 = 7'd7;
      qa.push_back(exp_t'{44'h0, 1'b0});
      qb.push_back(exp_t'{W7, 1'b0});
      tick();
      idle();
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
